// File: rtl/rgb_led_sequencer.sv
// Fixed-priority RGB status-LED sequencer with per-requester colour, blink mode and PWM.
// Optional breathe level ramp for mode 3 is enabled with RGB_LED_SEQUENCER_BREATHE_EN.
module rgb_led_sequencer #(
   parameter int NREQ      = 4,
   parameter int PWM_BITS  = 8,
   parameter int BLINK_DIV = 24,
   parameter logic [3*PWM_BITS-1:0] IDLE_RGB = 24'hFF0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*3*PWM_BITS-1:0] color,
   input  logic [NREQ*2-1:0]          mode,
   output logic [NREQ-1:0]            grant,
   output logic                       frame_tick,
   output logic                       led_r,
   output logic                       led_g,
   output logic                       led_b
);

   localparam int                CW      = 3*PWM_BITS;
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [BLINK_DIV-1:0] blink_cnt;
   logic [PWM_BITS-1:0]  eff_r, eff_g, eff_b;

   logic                 boundary;
   logic [NREQ-1:0]      grant_nxt;
   logic [CW-1:0]        src_color;
   logic [1:0]           src_mode;
   logic [BLINK_DIV-1:0] blink_nxt;
   logic                 show;
   logic [PWM_BITS-1:0]  eff_r_nxt, eff_g_nxt, eff_b_nxt;

   assign boundary  = (pwm_cnt == PWM_MAX);
   assign blink_nxt = blink_cnt + 1'b1;

   // Scan from the lowest priority upward so the lowest active index wins.
   always_comb begin
      grant_nxt = '0;
      src_color = IDLE_RGB;
      src_mode  = 2'd0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req[i]) begin
            grant_nxt = '0;
            grant_nxt[i] = 1'b1;
            src_color = color[i*CW +: CW];
            src_mode  = mode[i*2 +: 2];
         end
      end
   end

   always_comb begin
      case (src_mode)
         2'd1:    show = blink_nxt[BLINK_DIV-1];
         2'd2:    show = blink_nxt[BLINK_DIV-3];
         default: show = 1'b1;
      endcase
   end

`ifdef RGB_LED_SEQUENCER_BREATHE_EN
   logic [PWM_BITS-1:0] level;
   logic                dir_down;
   logic [PWM_BITS-1:0] level_nxt;
   logic                dir_down_nxt;

   function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] c,
                                                 input logic [PWM_BITS-1:0] l);
      logic [2*PWM_BITS-1:0] p;
      p = {{PWM_BITS{1'b0}}, c} * {{PWM_BITS{1'b0}}, l};
      return p[2*PWM_BITS-1:PWM_BITS];
   endfunction

   always_comb begin
      level_nxt    = dir_down ? level - 1'b1 : level + 1'b1;
      dir_down_nxt = dir_down;
      if (!dir_down && level_nxt == PWM_MAX)
         dir_down_nxt = 1'b1;
      else if (dir_down && level_nxt == '0)
         dir_down_nxt = 1'b0;
   end

   always_comb begin
      eff_r_nxt = src_color[CW-1 -: PWM_BITS];
      eff_g_nxt = src_color[2*PWM_BITS-1 -: PWM_BITS];
      eff_b_nxt = src_color[PWM_BITS-1:0];
      if (src_mode == 2'd3) begin
         eff_r_nxt = scale(src_color[CW-1 -: PWM_BITS], level_nxt);
         eff_g_nxt = scale(src_color[2*PWM_BITS-1 -: PWM_BITS], level_nxt);
         eff_b_nxt = scale(src_color[PWM_BITS-1:0], level_nxt);
      end
      if (!show) begin
         eff_r_nxt = '0;
         eff_g_nxt = '0;
         eff_b_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level    <= '0;
         dir_down <= 1'b0;
      end else if (boundary) begin
         level    <= level_nxt;
         dir_down <= dir_down_nxt;
      end
   end
`else
   always_comb begin
      eff_r_nxt = show ? src_color[CW-1 -: PWM_BITS]         : '0;
      eff_g_nxt = show ? src_color[2*PWM_BITS-1 -: PWM_BITS] : '0;
      eff_b_nxt = show ? src_color[PWM_BITS-1:0]             : '0;
   end
`endif

   // Duty compare uses the pre-update eff_* on the boundary cycle, so a
   // duty of max never lights the LED on the last cycle of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt    <= '0;
         blink_cnt  <= '0;
         eff_r      <= '0;
         eff_g      <= '0;
         eff_b      <= '0;
         grant      <= '0;
         frame_tick <= 1'b0;
         led_r      <= 1'b0;
         led_g      <= 1'b0;
         led_b      <= 1'b0;
      end else begin
         pwm_cnt    <= pwm_cnt + 1'b1;
         frame_tick <= boundary;
         led_r      <= (pwm_cnt < eff_r);
         led_g      <= (pwm_cnt < eff_g);
         led_b      <= (pwm_cnt < eff_b);
         if (boundary) begin
            grant     <= grant_nxt;
            eff_r     <= eff_r_nxt;
            eff_g     <= eff_g_nxt;
            eff_b     <= eff_b_nxt;
            blink_cnt <= blink_nxt;
         end
      end
   end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed bench for rgb_led_sequencer (NREQ=4, PWM_BITS=8, BLINK_DIV=4).
module tb_rgb_led_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [95:0] color = '0;
   logic [7:0]  mode = '0;
   logic [3:0]  grant;
   logic        frame_tick;
   logic        led_r, led_g, led_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   rgb_led_sequencer #(.NREQ(4), .PWM_BITS(8), .BLINK_DIV(4), .IDLE_RGB(24'hFF0000)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .color(color), .mode(mode),
      .grant(grant), .frame_tick(frame_tick),
      .led_r(led_r), .led_g(led_g), .led_b(led_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      #1;
      check("rst_grant", int'(grant), 0);
      check("rst_leds", int'({led_r, led_g, led_b}), 0);
      check("rst_tick", int'(frame_tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_tick();
      bit seen = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (frame_tick) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         check("tick_timeout", 0, 1);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $fatal(1, "FAIL tick_timeout");
      end
      check("tick_phase", cyc % 256, 0);
   endtask

   // Called on the frame_tick sample; leaves on the last sample of the frame.
   task automatic measure(output int nr, output int ng, output int nb,
                          output int first_g, output int grant_chg);
      logic [3:0] g0;
      nr = 0; ng = 0; nb = 0; first_g = -1; grant_chg = 0;
      g0 = grant;
      for (int s = 0; s < 256; s++) begin
         nr += int'(led_r);
         ng += int'(led_g);
         nb += int'(led_b);
         if (led_g && first_g < 0) first_g = s;
         if (grant !== g0) grant_chg++;
         if (s < 255) @(negedge clk);
      end
   endtask

   task automatic frame0_and_idle();
      int cnt = 0;
      int nr, ng, nb, fg, gc;
      for (int s = 0; s < 255; s++) begin
         cnt += int'(led_r | led_g | led_b);
         @(negedge clk);
      end
      check("frame0_dark", cnt, 0);
      wait_tick();
      measure(nr, ng, nb, fg, gc);
      check("idle_grant", int'(grant), 0);
      check("idle_r", nr, 255);
      check("idle_g", ng, 0);
      check("idle_b", nb, 0);
   endtask

   initial begin
      int nr, ng, nb, fg, gc, k, exp, lvl;

      @(negedge clk);
      do_reset();
      frame0_and_idle();

      // Requester 2 green solid
      color[2*24 +: 24] = {8'h00, 8'h40, 8'h00};
      req = 4'b0100;
      wait_tick();
      measure(nr, ng, nb, fg, gc);
      check("g2_grant", int'(grant), 4);
      check("g2_g", ng, 64);
      check("g2_first", fg, 1);
      check("g2_r", nr, 0);
      check("g2_b", nb, 0);
      check("g2_stable", gc, 0);

      // Priority with deferral
      color[3*24 +: 24] = {8'h00, 8'h00, 8'h10};
      color[1*24 +: 24] = {8'h20, 8'h00, 8'h00};
      req = 4'b1000;
      wait_tick();
      measure(nr, ng, nb, fg, gc);
      check("g3_grant", int'(grant), 8);
      check("g3_b", nb, 16);
      wait_tick();
      repeat (100) @(negedge clk);
      req = 4'b1010;
      repeat (50) @(negedge clk);
      check("defer_grant", int'(grant), 8);
      wait_tick();
      measure(nr, ng, nb, fg, gc);
      check("g1_grant", int'(grant), 2);
      check("g1_r", nr, 32);
      check("g1_b", nb, 0);
      check("g1_stable", gc, 0);
      wait_tick();
      repeat (100) @(negedge clk);
      req = 4'b1000;
      check("retain_grant", int'(grant), 2);
      wait_tick();
      measure(nr, ng, nb, fg, gc);
      check("back3_grant", int'(grant), 8);
      check("back3_b", nb, 16);

      // Owner drops while lower priority rises: same-boundary handover
      req = 4'b0100;
      wait_tick();
      measure(nr, ng, nb, fg, gc);
      check("handover_grant", int'(grant), 4);
      check("handover_g", ng, 64);

      // Slow blink on requester 0
      color[0 +: 24] = {8'h80, 8'h80, 8'h80};
      mode[1:0] = 2'd1;
      req = 4'b0101;
      for (int f = 0; f < 16; f++) begin
         wait_tick();
         k = cyc / 256;
         exp = ((k % 16) >= 8) ? 128 : 0;
         measure(nr, ng, nb, fg, gc);
         check("slow_r", nr, exp);
         check("slow_b", nb, exp);
      end
      check("slow_grant", int'(grant), 1);

      // Fast blink
      mode[1:0] = 2'd2;
      for (int f = 0; f < 4; f++) begin
         wait_tick();
         k = cyc / 256;
         exp = ((k % 4) >= 2) ? 128 : 0;
         measure(nr, ng, nb, fg, gc);
         check("fast_g", ng, exp);
      end

      // Breathe (solid when feature is not built)
      color[0 +: 24] = {8'hFF, 8'h00, 8'h00};
      mode[1:0] = 2'd3;
      for (int f = 0; f < 3; f++) begin
         wait_tick();
         k = cyc / 256;
         lvl = k % 510;
         if (lvl > 255) lvl = 510 - lvl;
`ifdef RGB_LED_SEQUENCER_BREATHE_EN
         exp = (255 * lvl) >> 8;
`else
         exp = 255;
`endif
         measure(nr, ng, nb, fg, gc);
         check("breathe_r", nr, exp);
         check("breathe_g", ng, 0);
      end

      // Mid-frame reset while granted
      wait_tick();
      repeat (100) @(negedge clk);
      check("pre_rst_grant", int'(grant), 1);
      do_reset();
      frame0_and_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
